// File: rtl/pll_ctrl_pkg.sv
// rtl/pll_ctrl_pkg.sv - shared types for the rPLL dynamic-divider sequencer
package pll_ctrl_pkg;

    localparam int SEL_W = 6;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } pll_state_t;

    typedef struct packed {
        logic [SEL_W-1:0] idsel;
        logic [SEL_W-1:0] fbdsel;
        logic [SEL_W-1:0] odsel;
    } pll_sel_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous status inputs
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_dyn_cfg_ctrl.sv
// rtl/pll_dyn_cfg_ctrl.sv - rPLL dynamic-divider sequencer: reset, lock qualify, retry, runtime reconfig
module pll_dyn_cfg_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int               RST_CYCLES    = 16,
    parameter int               LOCK_TIMEOUT  = 65536,
    parameter int               STABLE_CYCLES = 1024,
    parameter int               MAX_RETRIES   = 3,
    parameter logic [SEL_W-1:0] DEF_IDSEL     = '0,
    parameter logic [SEL_W-1:0] DEF_FBDSEL    = '0,
    parameter logic [SEL_W-1:0] DEF_ODSEL     = '0
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [SEL_W-1:0] cfg_idsel,
    input  logic [SEL_W-1:0] cfg_fbdsel,
    input  logic [SEL_W-1:0] cfg_odsel,
    input  logic             pll_lock,
    output logic             pll_reset,
    output logic [SEL_W-1:0] pll_idsel,
    output logic [SEL_W-1:0] pll_fbdsel,
    output logic [SEL_W-1:0] pll_odsel,
    output logic             clk_rst,
    output logic             ready,
    output logic             fail,
    output logic [7:0]       lock_loss_cnt
);

    localparam int RST_W = $clog2(RST_CYCLES) + 1;
    localparam int TMO_W = $clog2(LOCK_TIMEOUT) + 1;
    localparam int STB_W = $clog2(STABLE_CYCLES) + 1;
    localparam int RET_W = $clog2(MAX_RETRIES) + 1;

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0);
    localparam logic [RET_W-1:0] RET_MAX  = RET_W'(MAX_RETRIES);
    localparam pll_sel_t         DEF_SEL  = pll_sel_t'({DEF_IDSEL, DEF_FBDSEL, DEF_ODSEL});

    pll_state_t       state_q, state_d;
    logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [STB_W-1:0] stb_cnt_q, stb_cnt_d;
    logic [RET_W-1:0] retry_cnt_q, retry_cnt_d;
    pll_sel_t         sel_q, sel_d;
    logic [7:0]       loss_cnt_q, loss_cnt_d;
    logic             pll_reset_q, pll_reset_d;
    logic             clk_rst_q, clk_rst_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;
    logic             cfg_ready_q, cfg_ready_d;

    logic lock_s;
    logic go_run;
    logic cfg_accept;
    logic in_lock_wait;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (clkin),
        .reset (reset),
        .d     (pll_lock),
        .q     (lock_s)
    );

    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        stb_cnt_d    = stb_cnt_q;
        retry_cnt_d  = retry_cnt_q;
        sel_d        = sel_q;
        loss_cnt_d   = loss_cnt_q;
        go_run       = 1'b0;
        cfg_accept   = cfg_valid & cfg_ready_q;
        in_lock_wait = (state_q == ST_WAIT_LOCK) || (state_q == ST_STABLE);

        case (state_q)
            ST_RESET: begin
                rst_cnt_d = rst_cnt_q + 1'b1;
                tmo_cnt_d = '0;
                if (rst_cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            // The WAIT_LOCK sample that sees lock counts as the first stable cycle.
            ST_WAIT_LOCK: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (lock_s) begin
                    if (STABLE_CYCLES == 1) begin
                        go_run = 1'b1;
                    end else begin
                        state_d   = ST_STABLE;
                        stb_cnt_d = '0;
                    end
                end
            end
            ST_STABLE: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (stb_cnt_q == STB_LAST) begin
                    go_run = 1'b1;
                end else begin
                    stb_cnt_d = stb_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    if (loss_cnt_q != 8'hFF) begin
                        loss_cnt_d = loss_cnt_q + 1'b1;
                    end
                    retry_cnt_d = '0;
                    state_d     = ST_RESET;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase

        // A lock that qualifies on the last allowed cycle wins over the timeout.
        if (go_run) begin
            state_d     = ST_RUN;
            retry_cnt_d = '0;
        end else if (in_lock_wait && (tmo_cnt_q == TMO_LAST)) begin
            if (retry_cnt_q < RET_MAX) begin
                retry_cnt_d = retry_cnt_q + 1'b1;
                state_d     = ST_RESET;
            end else begin
                state_d = ST_FAIL;
            end
        end

        if (cfg_accept) begin
            sel_d       = pll_sel_t'({cfg_idsel, cfg_fbdsel, cfg_odsel});
            state_d     = ST_RESET;
            retry_cnt_d = '0;
        end

        if ((state_d == ST_RESET) && (state_q != ST_RESET)) begin
            rst_cnt_d = '0;
        end

        // Outputs follow the next state so they change on the same edge as the state.
        pll_reset_d = (state_d == ST_RESET) || (state_d == ST_FAIL);
        clk_rst_d   = (state_d != ST_RUN);
        ready_d     = (state_d == ST_RUN);
        fail_d      = (state_d == ST_FAIL);
        cfg_ready_d = (state_d == ST_RUN) || (state_d == ST_FAIL);
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q     <= ST_RESET;
            rst_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            stb_cnt_q   <= '0;
            retry_cnt_q <= '0;
            sel_q       <= DEF_SEL;
            loss_cnt_q  <= '0;
            pll_reset_q <= 1'b1;
            clk_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
            cfg_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            stb_cnt_q   <= stb_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            sel_q       <= sel_d;
            loss_cnt_q  <= loss_cnt_d;
            pll_reset_q <= pll_reset_d;
            clk_rst_q   <= clk_rst_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    assign pll_reset     = pll_reset_q;
    assign clk_rst       = clk_rst_q;
    assign ready         = ready_q;
    assign fail          = fail_q;
    assign cfg_ready     = cfg_ready_q;
    assign pll_idsel     = sel_q.idsel;
    assign pll_fbdsel    = sel_q.fbdsel;
    assign pll_odsel     = sel_q.odsel;
    assign lock_loss_cnt = loss_cnt_q;

endmodule
